// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, start/data/[parity]/stop; UART_TX_PARITY_EN adds an even-parity bit.
// Latency: a pushed byte starts on the first baud_tick at least one clk after the push.
// Backpressure: none; a push while full and not popping is dropped and sets sticky overflow.

module fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Caller only pushes when there is room (or a pop frees it) and only pops when non-empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
         if (push && !pop)      count <= count + (ADDR_W+1)'(1);
         else if (pop && !push) count <= count - (ADDR_W+1)'(1);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign full    = (count == (ADDR_W+1)'(DEPTH));
endmodule

module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int ADDR_W     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              baud_tick,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par_q;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t            state;
   logic [DATA_W-1:0] shift;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] head;
   logic              pop;
   logic              push;

   assign pop  = baud_tick && (count != '0) && (state == IDLE || state == STOP);
   assign push = wr_en && (!full || pop);

   fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .rd_data (head),
      .count   (count),
      .full    (full)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         shift      <= '0;
         bit_cnt    <= '0;
         tx_out     <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         frame_done <= baud_tick && (state == STOP);
         if (wr_en && full && !pop) overflow <= 1'b1;
         // A pop from IDLE or STOP always launches the next start bit, so STOP chains frames gap-free.
         if (pop) begin
            shift  <= head;
            tx_out <= 1'b0;
            state  <= START;
            busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q  <= ^head;
`endif
         end else if (baud_tick) begin
            case (state)
               IDLE: ;
               START: begin
                  tx_out  <= shift[0];
                  shift   <= shift >> 1;
                  bit_cnt <= '0;
                  state   <= DATA;
               end
               DATA: begin
                  if (bit_cnt < CNT_W'(DATA_W-1)) begin
                     tx_out  <= shift[0];
                     shift   <= shift >> 1;
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end else begin
`ifdef UART_TX_PARITY_EN
                     tx_out <= par_q;
                     state  <= PARITY;
`else
                     tx_out <= 1'b1;
                     state  <= STOP;
`endif
                  end
               end
`ifdef UART_TX_PARITY_EN
               PARITY: begin
                  tx_out <= 1'b1;
                  state  <= STOP;
               end
`endif
               STOP: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  tx_out <= 1'b1;
                  busy   <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus a random run against a frame-level line model.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   logic       clk = 1'b0;
   logic       reset, baud_tick, wr_en;
   logic [7:0] wr_data;
   logic       full, overflow, tx_out, busy, frame_done;
   logic [4:0] count;

   int total = 0;
   int bad = 0;

   // Model: bytes waiting, plus the index of the frame bit currently on the line (-1 = idle).
   logic [7:0]    mq[$];
   int            mpos;
   logic [FL-1:0] mframe;
   logic          exp_tx, exp_busy, exp_done, exp_ovf;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .baud_tick  (baud_tick),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .full       (full),
      .count      (count),
      .overflow   (overflow),
      .tx_out     (tx_out),
      .busy       (busy),
      .frame_done (frame_done)
   );

   // Line values of one frame in transmission order: bit 0 goes out first.
   function automatic logic [FL-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   // Drive one clock's inputs, advance the model over that edge, return at the next negedge.
   task automatic cyc(input logic t, input logic w, input logic [7:0] d, input logic r);
      int   sz;
      logic pop;
      baud_tick = t; wr_en = w; wr_data = d; reset = r;
      if (r) begin
         mq.delete(); mpos = -1;
         exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
      end else begin
         sz = mq.size();
         pop = t && (mpos == -1 || mpos == FL-1) && sz > 0;
         exp_done = t && (mpos == FL-1);
         if (t) begin
            if (mpos == -1 || mpos == FL-1) begin
               if (pop) begin mframe = frame_of(mq.pop_front()); mpos = 0; end
               else mpos = -1;
            end else mpos++;
            exp_tx = (mpos == -1) ? 1'b1 : mframe[mpos];
         end
         if (w) begin
            if (sz < 16 || pop) mq.push_back(d);
            else exp_ovf = 1'b1;
         end
         exp_busy = (mpos != -1);
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      cyc(0, 0, 8'd0, 1); cyc(0, 0, 8'd0, 1); cyc(0, 0, 8'd0, 0);
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_out); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
   endtask

   task automatic test_single;
      int seq[FL];
`ifdef UART_TX_PARITY_EN
      seq = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
`else
      seq = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
`endif
      cyc(0, 1, 8'd5, 0);
      total++; if (count !== 5'd1) begin bad++; $display("FAIL single_push_count: got %0d want 1", count); end
      for (int i = 0; i < FL; i++) begin
         cyc(1, 0, 8'd0, 0);
         total++; if (tx_out !== seq[i][0]) begin bad++; $display("FAIL single_bit%0d: got %b want %0d", i, tx_out, seq[i]); end
         cyc(0, 0, 8'd0, 0);
         total++; if (tx_out !== seq[i][0]) begin bad++; $display("FAIL single_hold%0d: got %b want %0d", i, tx_out, seq[i]); end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy%0d: got %b want 1", i, busy); end
      end
      cyc(1, 0, 8'd0, 0);
      total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_done: got %b want 1", frame_done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy: got %b want 0", busy); end
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL single_idle_tx: got %b want 1", tx_out); end
      cyc(0, 0, 8'd0, 0);
      total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_done_pulse: got %b want 0", frame_done); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] bytes_in [3];
      logic       bits [3*FL];
      logic [7:0] b;
      bytes_in[0] = 8'd5; bytes_in[1] = 8'd4; bytes_in[2] = 8'd3;
      for (int i = 0; i < 3; i++) cyc(0, 1, bytes_in[i], 0);
      total++; if (count !== 5'd3) begin bad++; $display("FAIL b2b_count: got %0d want 3", count); end
      for (int i = 0; i < 3*FL; i++) begin
         cyc(1, 0, 8'd0, 0);
         bits[i] = tx_out;
         if (i % FL == 0) begin
            total++; if (count !== 5'(2 - i/FL)) begin bad++; $display("FAIL b2b_step%0d: got %0d want %0d", i/FL, count, 2 - i/FL); end
            if (i > 0) begin
               total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL b2b_done%0d: got %b want 1", i/FL, frame_done); end
            end
         end
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d: got %b want 1", i, busy); end
      end
      for (int f = 0; f < 3; f++) begin
         for (int k = 0; k < 8; k++) b[k] = bits[f*FL + 1 + k];
         total++; if (bits[f*FL] !== 1'b0) begin bad++; $display("FAIL b2b_start%0d: got %b want 0", f, bits[f*FL]); end
         total++; if (bits[f*FL + FL-1] !== 1'b1) begin bad++; $display("FAIL b2b_stop%0d: got %b want 1", f, bits[f*FL + FL-1]); end
         total++; if (b !== bytes_in[f]) begin bad++; $display("FAIL b2b_byte%0d: got %0d want %0d", f, b, bytes_in[f]); end
      end
      cyc(1, 0, 8'd0, 0);
      total++; if (frame_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end: done=%b busy=%b want 1,0", frame_done, busy); end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 17; i++) begin
         cyc(0, 1, 8'($urandom), 0);
         total++; if (full !== (i >= 15)) begin bad++; $display("FAIL ovf_full%0d: got %b want %b", i, full, (i >= 15)); end
         total++; if (overflow !== (i == 16)) begin bad++; $display("FAIL ovf_flag%0d: got %b want %b", i, overflow, (i == 16)); end
      end
      total++; if (count !== 5'd16) begin bad++; $display("FAIL ovf_count: got %0d want 16", count); end
      for (int n = 0; n < 400 && (mq.size() > 0 || mpos != -1); n++) begin
         cyc(1, 0, 8'd0, 0);
         total++; if (tx_out !== exp_tx) begin bad++; $display("FAIL ovf_drain_tx%0d: got %b want %b", n, tx_out, exp_tx); end
      end
      total++; if (count !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL ovf_drained: count=%0d busy=%b want 0,0", count, busy); end
      for (int n = 0; n < 12; n++) begin
         cyc(1, 0, 8'd0, 0);
         total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL ovf_no17th%0d: got %b want 1", n, tx_out); end
      end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_reset_midframe;
      cyc(0, 1, 8'hA5, 0); cyc(0, 1, 8'h3C, 0);
      for (int i = 0; i < 5; i++) cyc(1, 0, 8'd0, 0);
      total++; if (tx_out !== exp_tx) begin bad++; $display("FAIL mid_d3: got %b want %b", tx_out, exp_tx); end
      cyc(0, 0, 8'd0, 1);
      total++; if (tx_out !== 1'b1) begin bad++; $display("FAIL mid_rst_tx: got %b want 1", tx_out); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", overflow); end
      for (int n = 0; n < 12; n++) begin
         cyc(1, 0, 8'd0, 0);
         total++; if (tx_out !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mid_quiet%0d: tx=%b busy=%b want 1,0", n, tx_out, busy); end
      end
   endtask

   task automatic test_full_pop_push;
      cyc(0, 0, 8'd0, 1);
      for (int i = 0; i < 16; i++) cyc(0, 1, 8'($urandom), 0);
      total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("FAIL fpp_fill: count=%0d full=%b want 16,1", count, full); end
      cyc(1, 1, 8'h5A, 0);
      total++; if (count !== 5'd16) begin bad++; $display("FAIL fpp_count: got %0d want 16", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
      total++; if (tx_out !== 1'b0) begin bad++; $display("FAIL fpp_start: got %b want 0", tx_out); end
      for (int n = 0; n < 400 && (mq.size() > 0 || mpos != -1); n++) begin
         cyc(1, 0, 8'd0, 0);
         total++; if (tx_out !== exp_tx) begin bad++; $display("FAIL fpp_drain_tx%0d: got %b want %b", n, tx_out, exp_tx); end
      end
      total++; if (count !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL fpp_drained: count=%0d busy=%b want 0,0", count, busy); end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      int         seq[2][FL];
      logic [7:0] vals [2];
      vals[0] = 8'd7; vals[1] = 8'd3;
      seq[0] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
      seq[1] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
      for (int v = 0; v < 2; v++) begin
         cyc(0, 1, vals[v], 0);
         for (int i = 0; i < FL; i++) begin
            cyc(1, 0, 8'd0, 0);
            total++; if (tx_out !== seq[v][i][0]) begin bad++; $display("FAIL par%0d_bit%0d: got %b want %0d", vals[v], i, tx_out, seq[v][i]); end
         end
         cyc(1, 0, 8'd0, 0);
         total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL par%0d_done: got %b want 1", vals[v], frame_done); end
      end
   endtask
`endif

   task automatic test_random;
      logic t, w, r;
      for (int n = 0; n < 3000; n++) begin
         t = ($urandom_range(0, 2) == 0);
         w = (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
         r = ($urandom_range(0, 599) == 0);
         cyc(t, w, 8'($urandom), r);
         total++; if (tx_out !== exp_tx) begin bad++; $display("FAIL rnd_tx@%0d: got %b want %b", n, tx_out, exp_tx); end
         total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy@%0d: got %b want %b", n, busy, exp_busy); end
         total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, count, mq.size()); end
         total++; if (full !== (mq.size() == 16)) begin bad++; $display("FAIL rnd_full@%0d: got %b want %b", n, full, (mq.size() == 16)); end
         total++; if (frame_done !== exp_done) begin bad++; $display("FAIL rnd_done@%0d: got %b want %b", n, frame_done, exp_done); end
         total++; if (overflow !== exp_ovf) begin bad++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, overflow, exp_ovf); end
      end
   endtask

   initial begin
      reset = 1'b1; baud_tick = 1'b0; wr_en = 1'b0; wr_data = 8'd0;
      mpos = -1; mframe = '1;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
      @(negedge clk);
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_reset_midframe;
      test_full_pop_push;
`ifdef UART_TX_PARITY_EN
      test_parity;
`endif
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
